key_event_ctrl: RTL and testbench

KEY_EVENT_CTRL -- requirements
Module: key_event_ctrl

---
 rtl/key_evt_pkg.sv | 30 +++
 rtl/key_evt_fifo.sv | 58 +++++
 rtl/key_event_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_key_event_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_evt_pkg.sv
// Shared definitions for the key event controller: event codes, per-key FSM
// states, queue entry layout and the default timing parameters.
package key_evt_pkg;

  localparam int unsigned NUM_KEYS           = 2;
  localparam int unsigned CLK_DIV_DEFAULT    = 50000;
  localparam int unsigned DB_MS_DEFAULT      = 12;
  localparam int unsigned LONG_MS_DEFAULT    = 500;
  localparam int unsigned REPEAT_MS_DEFAULT  = 100;
  localparam int unsigned FIFO_DEPTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    EVT_PRESS   = 2'b00,
    EVT_RELEASE = 2'b01,
    EVT_LONG    = 2'b10,
    EVT_REPEAT  = 2'b11
  } evt_type_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PRESS = 2'b01,
    ST_HOLD  = 2'b10
  } key_fsm_t;

  typedef struct packed {
    logic      key;
    evt_type_t typ;
  } evt_t;

endpackage

// File: rtl/key_evt_fifo.sv
// Event queue: power-of-two circular buffer with a valid/ready consumer side.
// A push is accepted while full provided the head is popped in the same cycle.
module key_evt_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  output logic             valid,
  input  logic             ready,
  output logic [WIDTH-1:0] data
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             pop;
  logic             wr;

  assign valid = (count != '0);
  assign full  = (count == (AW + 1)'(DEPTH));
  assign pop   = valid & ready;
  assign wr    = push & (~full | pop);
  assign data  = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/key_event_ctrl.sv
// Two-key front end: synchronise, debounce on a sample tick, detect
// press/long/repeat/release per key and queue the events for a consumer.
module key_event_ctrl
  import key_evt_pkg::*;
#(
  parameter int unsigned CLK_DIV    = CLK_DIV_DEFAULT,
  parameter int unsigned DB_MS      = DB_MS_DEFAULT,
  parameter int unsigned LONG_MS    = LONG_MS_DEFAULT,
  parameter int unsigned REPEAT_MS  = REPEAT_MS_DEFAULT,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic       Sys_CLK,
  input  logic       Sys_RST,
  input  logic [1:0] Key_In,
  output logic [1:0] Key_State,
  output logic       Evt_Valid,
  input  logic       Evt_Ready,
  output logic       Evt_Key,
  output logic [1:0] Evt_Type,
  output logic       Ovf,
  input  logic       Ovf_Clr
);

  localparam int unsigned TW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned HOLD_MAX = (LONG_MS > REPEAT_MS) ? LONG_MS : REPEAT_MS;
  localparam int unsigned HW       = $clog2(HOLD_MAX + 1);

  logic [1:0]       sync1;
  logic [1:0]       sync2;
  logic [TW-1:0]    tcnt;
  logic             tick;
  logic [DB_MS-1:0] hist     [NUM_KEYS];
  logic [DB_MS-1:0] hist_nxt [NUM_KEYS];

  key_fsm_t         st_q     [NUM_KEYS];
  key_fsm_t         st_d     [NUM_KEYS];
  logic [HW-1:0]    hold_q   [NUM_KEYS];
  logic [HW-1:0]    hold_d   [NUM_KEYS];
  logic [NUM_KEYS-1:0] evt_fire;
  evt_type_t        evt_type [NUM_KEYS];

  logic [NUM_KEYS-1:0] pend_v;
  evt_type_t        pend_t   [NUM_KEYS];
  logic [NUM_KEYS-1:0] drop;
  logic             rr;
  logic             grant_v;
  logic             grant_k;
  logic             fifo_full;
  logic             pop;
  evt_t             push_evt;
  evt_t             head_evt;

  assign tick = (tcnt == TW'(CLK_DIV - 1));

  always_comb begin
    for (int unsigned k = 0; k < NUM_KEYS; k++) begin
      hist_nxt[k] = {hist[k][DB_MS-2:0], sync2[k]};
    end
  end

  always_ff @(posedge Sys_CLK) begin
    if (Sys_RST) begin
      sync1     <= '0;
      sync2     <= '0;
      tcnt      <= '0;
      Key_State <= '0;
      for (int unsigned k = 0; k < NUM_KEYS; k++) begin
        hist[k] <= '0;
      end
    end else begin
      sync1 <= Key_In;
      sync2 <= sync1;
      tcnt  <= tick ? '0 : tcnt + TW'(1);
      if (tick) begin
        for (int unsigned k = 0; k < NUM_KEYS; k++) begin
          hist[k] <= hist_nxt[k];
          if (&hist_nxt[k]) begin
            Key_State[k] <= 1'b1;
          end else if (~|hist_nxt[k]) begin
            Key_State[k] <= 1'b0;
          end
        end
      end
    end
  end

  // Level-based edge detection: the FSM itself remembers the last accepted
  // level, so a rise/fall is seen exactly one cycle after Key_State changes.
  always_comb begin
    for (int unsigned k = 0; k < NUM_KEYS; k++) begin
      st_d[k]     = st_q[k];
      hold_d[k]   = hold_q[k];
      evt_fire[k] = 1'b0;
      evt_type[k] = EVT_PRESS;
      case (st_q[k])
        ST_IDLE: begin
          if (Key_State[k]) begin
            st_d[k]     = ST_PRESS;
            hold_d[k]   = '0;
            evt_fire[k] = 1'b1;
            evt_type[k] = EVT_PRESS;
          end
        end
        ST_PRESS, ST_HOLD: begin
          if (!Key_State[k]) begin
            st_d[k]     = ST_IDLE;
            hold_d[k]   = '0;
            evt_fire[k] = 1'b1;
            evt_type[k] = EVT_RELEASE;
          end else if (tick) begin
            if (st_q[k] == ST_PRESS && hold_q[k] == HW'(LONG_MS - 1)) begin
              st_d[k]     = ST_HOLD;
              hold_d[k]   = '0;
              evt_fire[k] = 1'b1;
              evt_type[k] = EVT_LONG;
            end else if (st_q[k] == ST_HOLD && hold_q[k] == HW'(REPEAT_MS - 1)) begin
              hold_d[k]   = '0;
              evt_fire[k] = 1'b1;
              evt_type[k] = EVT_REPEAT;
            end else begin
              hold_d[k] = hold_q[k] + HW'(1);
            end
          end
        end
        default: st_d[k] = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Sys_CLK) begin
    for (int unsigned k = 0; k < NUM_KEYS; k++) begin
      if (Sys_RST) begin
        st_q[k]   <= ST_IDLE;
        hold_q[k] <= '0;
      end else begin
        st_q[k]   <= st_d[k];
        hold_q[k] <= hold_d[k];
      end
    end
  end

  assign pop = Evt_Valid & Evt_Ready;

  always_comb begin
    grant_v = 1'b0;
    grant_k = 1'b0;
    if (!fifo_full || pop) begin
      if (pend_v[rr]) begin
        grant_v = 1'b1;
        grant_k = rr;
      end else if (pend_v[~rr]) begin
        grant_v = 1'b1;
        grant_k = ~rr;
      end
    end
    push_evt = '{key: grant_k, typ: pend_t[grant_k]};
    // A slot being granted this cycle is free for a new event.
    for (int unsigned k = 0; k < NUM_KEYS; k++) begin
      drop[k] = evt_fire[k] & pend_v[k] & ~(grant_v & (grant_k == 1'(k)));
    end
  end

  always_ff @(posedge Sys_CLK) begin
    if (Sys_RST) begin
      pend_v <= '0;
      rr     <= 1'b0;
      Ovf    <= 1'b0;
      for (int unsigned k = 0; k < NUM_KEYS; k++) begin
        pend_t[k] <= EVT_PRESS;
      end
    end else begin
      for (int unsigned k = 0; k < NUM_KEYS; k++) begin
        if (evt_fire[k] && !drop[k]) begin
          pend_v[k] <= 1'b1;
          pend_t[k] <= evt_type[k];
        end else if (grant_v && grant_k == 1'(k)) begin
          pend_v[k] <= 1'b0;
        end
      end
      if (grant_v) begin
        rr <= ~grant_k;
      end
      if (|drop) begin
        Ovf <= 1'b1;
      end else if (Ovf_Clr) begin
        Ovf <= 1'b0;
      end
    end
  end

  key_evt_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH($bits(evt_t))
  ) u_fifo (
    .clk      (Sys_CLK),
    .rst      (Sys_RST),
    .push     (grant_v),
    .push_data(push_evt),
    .full     (fifo_full),
    .valid    (Evt_Valid),
    .ready    (Evt_Ready),
    .data     (head_evt)
  );

  assign Evt_Key  = head_evt.key;
  assign Evt_Type = head_evt.typ;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Bench for key_event_ctrl: directed phase table, hand sequences for the
// ordering/reset corners, and a randomized run against a behavioural model.
module tb_key_event_ctrl;

  localparam int CLK_DIV   = 4;
  localparam int DB_MS     = 3;
  localparam int LONG_MS   = 8;
  localparam int REPEAT_MS = 4;
  localparam int DEPTH     = 4;

  localparam bit [1:0] T_PRESS   = 2'b00;
  localparam bit [1:0] T_RELEASE = 2'b01;
  localparam bit [1:0] T_LONG    = 2'b10;
  localparam bit [1:0] T_REPEAT  = 2'b11;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] key_in;
  logic [1:0] key_state;
  logic       evt_valid;
  logic       evt_ready;
  logic       evt_key;
  logic [1:0] evt_type;
  logic       ovf;
  logic       ovf_clr;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  key_event_ctrl #(
    .CLK_DIV(CLK_DIV),
    .DB_MS(DB_MS),
    .LONG_MS(LONG_MS),
    .REPEAT_MS(REPEAT_MS),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .Sys_CLK  (clk),
    .Sys_RST  (rst),
    .Key_In   (key_in),
    .Key_State(key_state),
    .Evt_Valid(evt_valid),
    .Evt_Ready(evt_ready),
    .Evt_Key  (evt_key),
    .Evt_Type (evt_type),
    .Ovf      (ovf),
    .Ovf_Clr  (ovf_clr)
  );

  always #5 clk = ~clk;

  // Behavioural model: run-length debounce, ticks-since-press counter,
  // queues for the per-key slots and the event FIFO.
  int       m_tcnt;
  bit [1:0] m_s1, m_s2, m_ks;
  bit       m_last [2];
  int       m_run  [2];
  bit       m_pr   [2];
  int       m_held [2];
  bit       m_pv   [2];
  bit [1:0] m_pt   [2];
  bit [2:0] m_q[$];
  int       m_rr;
  bit       m_ovf;

  bit [2:0] got[$];
  int       gotc[$];

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void model_edge();
    bit       tick;
    bit [1:0] nks;
    bit       evv [2];
    bit [1:0] evt [2];
    bit       pop;
    int       g;
    bit       drop;
    if (rst) begin
      m_tcnt = 0; m_s1 = 0; m_s2 = 0; m_ks = 0; m_q.delete();
      m_rr = 0; m_ovf = 0;
      for (int k = 0; k < 2; k++) begin
        m_last[k] = 0; m_run[k] = DB_MS; m_pr[k] = 0; m_held[k] = 0;
        m_pv[k] = 0; m_pt[k] = 0;
      end
      return;
    end
    tick = (m_tcnt == CLK_DIV - 1);
    nks  = m_ks;
    for (int k = 0; k < 2; k++) begin
      evv[k] = 0;
      evt[k] = T_PRESS;
      if (tick) begin
        if (m_s2[k] == m_last[k]) begin
          if (m_run[k] < DB_MS) m_run[k]++;
        end else begin
          m_last[k] = m_s2[k];
          m_run[k]  = 1;
        end
        if (m_run[k] >= DB_MS) nks[k] = m_last[k];
      end
      if (!m_pr[k] && m_ks[k]) begin
        evv[k] = 1; evt[k] = T_PRESS; m_pr[k] = 1; m_held[k] = 0;
      end else if (m_pr[k] && !m_ks[k]) begin
        evv[k] = 1; evt[k] = T_RELEASE; m_pr[k] = 0;
      end else if (m_pr[k] && tick) begin
        m_held[k]++;
        if (m_held[k] == LONG_MS) begin
          evv[k] = 1; evt[k] = T_LONG;
        end else if (m_held[k] > LONG_MS && (m_held[k] - LONG_MS) % REPEAT_MS == 0) begin
          evv[k] = 1; evt[k] = T_REPEAT;
        end
      end
    end
    pop = (m_q.size() > 0) && evt_ready;
    g = -1;
    if (m_q.size() < DEPTH || pop) begin
      if (m_pv[m_rr]) g = m_rr;
      else if (m_pv[1 - m_rr]) g = 1 - m_rr;
    end
    if (pop) void'(m_q.pop_front());
    if (g >= 0) begin
      m_q.push_back({g[0], m_pt[g]});
      m_pv[g] = 0;
      m_rr = 1 - g;
    end
    drop = 0;
    for (int k = 0; k < 2; k++) begin
      if (evv[k]) begin
        if (m_pv[k]) drop = 1;
        else begin
          m_pv[k] = 1; m_pt[k] = evt[k];
        end
      end
    end
    if (drop) m_ovf = 1;
    else if (ovf_clr) m_ovf = 0;
    m_ks   = nks;
    m_s2   = m_s1;
    m_s1   = key_in;
    m_tcnt = tick ? 0 : m_tcnt + 1;
  endfunction

  task automatic step();
    bit       pop_seen;
    bit [2:0] head;
    bit [2:0] mh;
    pop_seen = evt_valid && evt_ready;
    head     = {evt_key, evt_type};
    @(posedge clk);
    cyc++;
    model_edge();
    if (pop_seen) begin
      got.push_back(head);
      gotc.push_back(cyc);
    end
    #1;
    chk("key_state", int'(key_state), int'(m_ks));
    chk("evt_valid", int'(evt_valid), int'(m_q.size() > 0));
    chk("ovf", int'(ovf), int'(m_ovf));
    if (m_q.size() > 0) begin
      mh = m_q[0];
      chk("evt_key", int'(evt_key), int'(mh[2]));
      chk("evt_type", int'(evt_type), int'(mh[1:0]));
    end
  endtask

  task automatic do_reset();
    rst = 1;
    repeat (3) step();
    rst = 0;
    got.delete();
    gotc.delete();
  endtask

  typedef struct {
    string    name;
    bit       rst;
    bit [1:0] key;
    bit       rdy;
    bit       clr;
    int       cycles;
    bit [1:0] ks;
    bit       valid;
    bit       ovf;
    int       pops;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int last;
    bit [2:0] e;
    rst = 1; key_in = 0; evt_ready = 1; ovf_clr = 0;

    tbl[0] = '{"reset",           1, 2'b00, 1, 0,   4, 2'b00, 0, 0, 0};
    tbl[1] = '{"idle",            0, 2'b00, 1, 0,   8, 2'b00, 0, 0, 0};
    tbl[2] = '{"fill_hold",       0, 2'b01, 0, 0, 160, 2'b01, 1, 1, 0};
    tbl[3] = '{"release_blocked", 0, 2'b00, 0, 0,  24, 2'b00, 1, 1, 0};
    tbl[4] = '{"ovf_clr",         0, 2'b00, 0, 1,   1, 2'b00, 1, 0, 0};
    tbl[5] = '{"drain",           0, 2'b00, 1, 0,  12, 2'b00, 0, 0, 5};

    foreach (tbl[i]) begin
      got.delete();
      gotc.delete();
      rst = tbl[i].rst; key_in = tbl[i].key; evt_ready = tbl[i].rdy; ovf_clr = tbl[i].clr;
      repeat (tbl[i].cycles) step();
      chk({tbl[i].name, "_ks"},    int'(key_state), int'(tbl[i].ks));
      chk({tbl[i].name, "_valid"}, int'(evt_valid), int'(tbl[i].valid));
      chk({tbl[i].name, "_ovf"},   int'(ovf), int'(tbl[i].ovf));
      chk({tbl[i].name, "_pops"},  got.size(), tbl[i].pops);
      if (tbl[i].rst) begin
        chk("reset_evt_key", int'(evt_key), 0);
        chk("reset_evt_type", int'(evt_type), 0);
      end
    end
    ovf_clr = 0;
    // drained order after overflow: 4 queued + 1 pending, all key 0
    if (got.size() == 5) begin
      chk("drain0", int'(got[0]), int'({1'b0, T_PRESS}));
      chk("drain1", int'(got[1]), int'({1'b0, T_LONG}));
      chk("drain2", int'(got[2]), int'({1'b0, T_REPEAT}));
      chk("drain3", int'(got[3]), int'({1'b0, T_REPEAT}));
      chk("drain4", int'(got[4]), int'({1'b0, T_REPEAT}));
      chk("drain_back_to_back", gotc[4] - gotc[0], 4);
    end

    // long press with repeats, then release
    evt_ready = 1; key_in = 0;
    do_reset();
    key_in = 2'b01;
    repeat (160) step();
    key_in = 2'b00;
    last = cyc;
    repeat (40) step();
    chk("k035_count_ge5", int'(got.size() >= 5), 1);
    if (got.size() >= 5) begin
      chk("k035_press", int'(got[0]), int'({1'b0, T_PRESS}));
      chk("k035_long", int'(got[1]), int'({1'b0, T_LONG}));
      chk("k035_long_gap", gotc[1] - gotc[0], LONG_MS * CLK_DIV - 1);
      chk("k035_rep1", int'(got[2]), int'({1'b0, T_REPEAT}));
      chk("k035_rep1_gap", gotc[2] - gotc[1], REPEAT_MS * CLK_DIV);
      chk("k035_rep2", int'(got[3]), int'({1'b0, T_REPEAT}));
      chk("k035_rep2_gap", gotc[3] - gotc[2], REPEAT_MS * CLK_DIV);
      e = got[got.size() - 1];
      chk("k035_release", int'(e), int'({1'b0, T_RELEASE}));
      n = gotc[gotc.size() - 1] - last;
      chk("k035_release_lat", int'(n >= 14 && n <= 17), 1);
    end

    // bouncing key 1: one toggle per sample tick never settles
    do_reset();
    for (int i = 0; i < 20; i++) begin
      key_in[1] = ~key_in[1];
      repeat (CLK_DIV) step();
    end
    key_in = 2'b00;
    repeat (20) step();
    chk("bounce_no_events", got.size(), 0);
    chk("bounce_ks1", int'(key_state[1]), 0);

    // simultaneous pairs and round-robin order
    do_reset();
    key_in = 2'b11; repeat (24) step();
    key_in = 2'b00; repeat (24) step();
    key_in = 2'b01; repeat (24) step();
    key_in = 2'b00; repeat (24) step();
    key_in = 2'b11; repeat (24) step();
    chk("rr_count", got.size(), 8);
    if (got.size() == 8) begin
      chk("rr_pair1_first", int'(got[0]), int'({1'b0, T_PRESS}));
      chk("rr_pair1_second", int'(got[1]), int'({1'b1, T_PRESS}));
      chk("rr_pair1_adjacent", gotc[1] - gotc[0], 1);
      chk("rr_pair2_first", int'(got[6]), int'({1'b1, T_PRESS}));
      chk("rr_pair2_second", int'(got[7]), int'({1'b0, T_PRESS}));
      chk("rr_pair2_adjacent", gotc[7] - gotc[6], 1);
    end
    key_in = 2'b00; repeat (24) step();

    // reset with events queued and key held
    do_reset();
    evt_ready = 0; key_in = 2'b01;
    repeat (64) step();
    chk("rst_pre_valid", int'(evt_valid), 1);
    rst = 1;
    step();
    chk("rst_valid_dropped", int'(evt_valid), 0);
    rst = 0; evt_ready = 1;
    got.delete(); gotc.delete();
    n = 0;
    while (n < 100 && !evt_valid) begin
      step();
      n++;
    end
    chk("rst_press_latency", n, 2 + DB_MS * CLK_DIV);
    chk("rst_press_type", int'(evt_type), int'(T_PRESS));
    chk("rst_press_key", int'(evt_key), 0);
    repeat (10) step();
    chk("rst_no_release", got.size(), 1);

    // randomized run against the model
    key_in = 0;
    do_reset();
    for (int seg = 0; seg < 16; seg++) begin
      int rate;
      int rdy_pct;
      rate    = $urandom_range(1, 40);
      rdy_pct = $urandom_range(5, 100);
      for (int i = 0; i < 256; i++) begin
        for (int k = 0; k < 2; k++) begin
          if ($urandom_range(0, 999) < rate) key_in[k] = ~key_in[k];
        end
        evt_ready = ($urandom_range(1, 100) <= rdy_pct);
        ovf_clr   = ($urandom_range(0, 39) == 0);
        rst       = ($urandom_range(0, 1499) == 0);
        step();
      end
    end
    rst = 0; ovf_clr = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
